// File: rtl/lstm_cell_update.sv
// Element-wise LSTM cell/hidden update: c = f*c + i*g, h = o*tanh(c).
// Optional macro CELL_SATURATE_EN clamps c instead of wrapping.
module lstm_cell_update #(
  parameter int HIDDEN_SZ      = 32,
  parameter int QN             = 7,
  parameter int QM             = 10,
  parameter int BITWIDTH       = QN + QM + 1,
  parameter int LAYER_BITWIDTH = BITWIDTH * HIDDEN_SZ
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      beginCalc,
  input  logic                      clearState,
  input  logic [LAYER_BITWIDTH-1:0] inputGate,
  input  logic [LAYER_BITWIDTH-1:0] forgetGate,
  input  logic [LAYER_BITWIDTH-1:0] outputGate,
  input  logic [LAYER_BITWIDTH-1:0] candGate,
  output logic [LAYER_BITWIDTH-1:0] cellState,
  output logic [LAYER_BITWIDTH-1:0] outputVec,
  output logic                      dataReady,
  output logic                      busy
);

  localparam int IW = $clog2(HIDDEN_SZ);

  localparam logic signed [BITWIDTH-1:0] C_MAX =
    {1'b0, {(BITWIDTH-1){1'b1}}};
  localparam logic signed [BITWIDTH-1:0] C_MIN =
    {1'b1, {(BITWIDTH-1){1'b0}}};
  localparam logic signed [BITWIDTH-1:0] C_ONE =
    BITWIDTH'(1 << QM);
  localparam logic signed [BITWIDTH-1:0] C_HALF =
    BITWIDTH'(1 << (QM - 1));
  localparam logic signed [BITWIDTH-1:0] C_KNEE =
    BITWIDTH'(5 << (QM - 1));
  localparam logic signed [BITWIDTH-1:0] C_OFS =
    BITWIDTH'(3 << (QM - 3));

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DRAIN,
    S_DONE
  } state_t;

  function automatic logic signed [BITWIDTH-1:0] f_mul(
    input logic signed [BITWIDTH-1:0] a,
    input logic signed [BITWIDTH-1:0] b
  );
    logic signed [2*BITWIDTH-1:0] p;
    p = a * b;
    return BITWIDTH'(p >>> QM);
  endfunction

  function automatic logic signed [BITWIDTH-1:0] f_tanh(
    input logic signed [BITWIDTH-1:0] x
  );
    logic signed [BITWIDTH-1:0] a;
    logic signed [BITWIDTH-1:0] r;
    if (x == C_MIN) a = C_MAX;
    else if (x < 0) a = -x;
    else a = x;
    if (a < C_HALF) r = a;
    else if (a < C_KNEE) r = (a >>> 2) + C_OFS;
    else r = C_ONE;
    return (x < 0) ? -r : r;
  endfunction

  state_t                      r_state;
  logic [IW-1:0]               r_idx;
  logic                        r_drain;
  logic                        r_busy;
  logic                        r_ready;
  logic [LAYER_BITWIDTH-1:0]   r_i;
  logic [LAYER_BITWIDTH-1:0]   r_f;
  logic [LAYER_BITWIDTH-1:0]   r_o;
  logic [LAYER_BITWIDTH-1:0]   r_g;
  logic [LAYER_BITWIDTH-1:0]   r_cell;
  logic [LAYER_BITWIDTH-1:0]   r_out;

  logic                        r_s1_v;
  logic [IW-1:0]               r_s1_idx;
  logic signed [BITWIDTH-1:0]  r_s1_pf;
  logic signed [BITWIDTH-1:0]  r_s1_pi;
  logic                        r_s2_v;
  logic [IW-1:0]               r_s2_idx;
  logic signed [BITWIDTH-1:0]  r_s2_t;

  logic                        w_idle;
  logic                        w_issue;
  logic                        w_clear;
  logic signed [BITWIDTH-1:0]  w_i;
  logic signed [BITWIDTH-1:0]  w_f;
  logic signed [BITWIDTH-1:0]  w_g;
  logic signed [BITWIDTH-1:0]  w_c;
  logic signed [BITWIDTH-1:0]  w_o;
  logic signed [BITWIDTH-1:0]  w_cnew;

  assign w_idle  = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_issue = (r_state == S_CALC);
  assign w_clear = clearState && w_idle;

  assign w_i = r_i[r_idx * BITWIDTH +: BITWIDTH];
  assign w_f = r_f[r_idx * BITWIDTH +: BITWIDTH];
  assign w_g = r_g[r_idx * BITWIDTH +: BITWIDTH];
  assign w_c = r_cell[r_idx * BITWIDTH +: BITWIDTH];
  assign w_o = r_o[r_s2_idx * BITWIDTH +: BITWIDTH];

`ifdef CELL_SATURATE_EN
  logic signed [BITWIDTH:0] w_sum;
  assign w_sum = {r_s1_pf[BITWIDTH-1], r_s1_pf}
               + {r_s1_pi[BITWIDTH-1], r_s1_pi};
  assign w_cnew = (w_sum[BITWIDTH] != w_sum[BITWIDTH-1])
                ? (w_sum[BITWIDTH] ? C_MIN : C_MAX)
                : w_sum[BITWIDTH-1:0];
`else
  // keeping only the low bits of the wide sum is a plain wrap
  assign w_cnew = r_s1_pf + r_s1_pi;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_drain <= 1'b0;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
      r_i     <= '0;
      r_f     <= '0;
      r_o     <= '0;
      r_g     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (beginCalc) begin
            r_state <= S_CALC;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_i     <= inputGate;
            r_f     <= forgetGate;
            r_o     <= outputGate;
            r_g     <= candGate;
          end
        end
        S_CALC: begin
          r_ready <= 1'b0;
          r_idx   <= r_idx + IW'(1);
          if (r_idx == IW'(HIDDEN_SZ - 1)) begin
            r_state <= S_DRAIN;
            r_drain <= 1'b0;
          end
        end
        S_DRAIN: begin
          r_drain <= 1'b1;
          if (r_drain) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1_v   <= 1'b0;
      r_s1_idx <= '0;
      r_s1_pf  <= '0;
      r_s1_pi  <= '0;
      r_s2_v   <= 1'b0;
      r_s2_idx <= '0;
      r_s2_t   <= '0;
      r_cell   <= '0;
      r_out    <= '0;
    end else begin
      r_s1_v   <= w_issue;
      r_s1_idx <= r_idx;
      r_s1_pf  <= f_mul(w_f, w_c);
      r_s1_pi  <= f_mul(w_i, w_g);
      r_s2_v   <= r_s1_v;
      r_s2_idx <= r_s1_idx;
      r_s2_t   <= f_tanh(w_cnew);
      if (w_clear) begin
        r_cell <= '0;
        r_out  <= '0;
      end else begin
        if (r_s1_v)
          r_cell[r_s1_idx * BITWIDTH +: BITWIDTH] <= w_cnew;
        if (r_s2_v)
          r_out[r_s2_idx * BITWIDTH +: BITWIDTH] <= f_mul(w_o, r_s2_t);
      end
    end
  end

  assign cellState = r_cell;
  assign outputVec = r_out;
  assign dataReady = r_ready;
  assign busy      = r_busy;

endmodule

// File: tb/tb_lstm_cell_update.sv
// Directed bench for lstm_cell_update with hand-computed Q7.10 results.
// Expected overflow values follow CELL_SATURATE_EN when defined.
module tb_lstm_cell_update;

  localparam int N  = 32;
  localparam int BW = 18;
  localparam int LW = BW * N;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          beginCalc = 1'b0;
  logic          clearState = 1'b0;
  logic [LW-1:0] inputGate = '0;
  logic [LW-1:0] forgetGate = '0;
  logic [LW-1:0] outputGate = '0;
  logic [LW-1:0] candGate = '0;
  logic [LW-1:0] cellState;
  logic [LW-1:0] outputVec;
  logic          dataReady;
  logic          busy;

  int n_chk = 0;
  int n_err = 0;

  lstm_cell_update dut (
    .clock      (clock),
    .reset      (reset),
    .beginCalc  (beginCalc),
    .clearState (clearState),
    .inputGate  (inputGate),
    .forgetGate (forgetGate),
    .outputGate (outputGate),
    .candGate   (candGate),
    .cellState  (cellState),
    .outputVec  (outputVec),
    .dataReady  (dataReady),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] rep(input int v);
    logic [LW-1:0] r;
    for (int k = 0; k < N; k++) r[k*BW +: BW] = BW'(v);
    return r;
  endfunction

  task automatic set_all(input int i, input int f,
                         input int o, input int g);
    inputGate  = rep(i);
    forgetGate = rep(f);
    outputGate = rep(o);
    candGate   = rep(g);
  endtask

  task automatic pulse_begin(input bit clr);
    @(negedge clock);
    beginCalc  = 1'b1;
    clearState = clr;
    @(posedge clock);
    #1;
    beginCalc  = 1'b0;
    clearState = 1'b0;
  endtask

  // counts edges after T0 until dataReady; optional mid-run pulse
  task automatic wait_ready(input int mid_at, output int lat);
    lat = 0;
    do begin
      if (lat + 1 == mid_at) begin
        @(negedge clock);
        beginCalc = 1'b1;
        set_all(3, 5, 7, 9);
      end
      @(posedge clock);
      #1;
      beginCalc = 1'b0;
      lat++;
    end while (!dataReady && lat < 100);
  endtask

  task automatic chk_vec(input string tag,
                         input int ec, input int eh);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("%s_c%0d", tag, k),
          int'($signed(cellState[k*BW +: BW])), ec);
      chk($sformatf("%s_h%0d", tag, k),
          int'($signed(outputVec[k*BW +: BW])), eh);
    end
  endtask

  int lat;
  int seen;
  int ovf_c;
  int ovf_h;

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk("rst_cell", int'(|cellState), 0);
    chk("rst_out", int'(|outputVec), 0);
    chk("rst_ready", int'(dataReady), 0);
    chk("rst_busy", int'(busy), 0);
    @(negedge clock);
    reset = 1'b0;

    // first step: c = 0*0 + 1.0*0.5
    set_all(1024, 0, 1024, 512);
    pulse_begin(1'b1);
    chk("s1_busy", int'(busy), 1);
    wait_ready(0, lat);
    chk("s1_lat", lat, 34);
    chk("s1_busy_done", int'(busy), 0);
    chk_vec("s1", 512, 512);

    // second step without clear: 0.5 + 1.0 = 1.5
    set_all(1024, 1024, 512, 1024);
    pulse_begin(1'b0);
    wait_ready(0, lat);
    chk("s2_lat", lat, 34);
    chk_vec("s2", 1536, 384);

    set_all(1024, 0, 1024, -3072);
    pulse_begin(1'b1);
    wait_ready(0, lat);
    chk("neg_lat", lat, 34);
    chk_vec("neg", -3072, -1024);

    // ramp: g[k] = k*64 crosses the 0.5 knee at k = 8
    set_all(1024, 0, 1024, 0);
    for (int k = 0; k < N; k++) candGate[k*BW +: BW] = BW'(k * 64);
    pulse_begin(1'b1);
    wait_ready(0, lat);
    chk("ramp_lat", lat, 34);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("ramp_c%0d", k),
          int'($signed(cellState[k*BW +: BW])), k * 64);
      chk($sformatf("ramp_h%0d", k),
          int'($signed(outputVec[k*BW +: BW])),
          (k < 8) ? k * 64 : k * 16 + 384);
    end

    set_all(1024, 1024, 1024, 130048);
    pulse_begin(1'b1);
    wait_ready(0, lat);
    chk_vec("ovf1", 130048, 1024);
    pulse_begin(1'b0);
    wait_ready(0, lat);
`ifdef CELL_SATURATE_EN
    ovf_c = 131071;
    ovf_h = 1024;
`else
    ovf_c = -2048;
    ovf_h = -896;
`endif
    chk_vec("ovf2", ovf_c, ovf_h);

    // beginCalc at T0+5 with garbage gates must be ignored
    set_all(1024, 0, 1024, 512);
    pulse_begin(1'b1);
    wait_ready(5, lat);
    chk("mid_lat", lat, 34);
    chk_vec("mid", 512, 512);

    set_all(1024, 0, 1024, 512);
    pulse_begin(1'b1);
    repeat (9) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("mrst_cell", int'(|cellState), 0);
    chk("mrst_out", int'(|outputVec), 0);
    chk("mrst_ready", int'(dataReady), 0);
    chk("mrst_busy", int'(busy), 0);
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (dataReady) seen++;
    end
    chk("mrst_noready", seen, 0);
    chk("mrst_idle_busy", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
